// File: rtl/flash_sample_reader_pkg.sv
// Shared jukebox types: reader FSM states, song address bounds, keyboard key codes
// and the sample-byte helper used by flash_sample_reader.
package flash_sample_reader_pkg;

    localparam int unsigned FLASH_ADDR_W   = 23;
    localparam int unsigned FLASH_DATA_W   = 32;
    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned BYTEEN_W       = 4;
    localparam int unsigned WDOG_W         = 8;

    localparam logic [FLASH_ADDR_W-1:0] SONG_START_ADDR = 23'h00000;
    localparam logic [FLASH_ADDR_W-1:0] SONG_END_ADDR   = 23'h7FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_OUT_FIRST,
        ST_OUT_SECOND,
        ST_ADVANCE,
        ST_RESTART
    } reader_state_t;

    // ASCII key codes decoded by the keyboard control FSM upstream
    typedef enum logic [7:0] {
        CHARACTER_B = 8'h42,
        CHARACTER_D = 8'h44,
        CHARACTER_E = 8'h45,
        CHARACTER_F = 8'h46,
        CHARACTER_R = 8'h52
    } key_char_t;

    // Upper byte of the selected 16-bit half of a flash word (hi=1 selects [31:16])
    function automatic logic [SAMPLE_W-1:0] half_msb(input logic [FLASH_DATA_W-1:0] w,
                                                     input logic hi);
        logic [15:0] h;
        h = hi ? w[31:16] : w[15:0];
        return SAMPLE_W'(h >> 8);
    endfunction

endpackage

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read port between the sample reader (master) and the song flash (slave).
interface flash_sample_reader_if #(
    parameter int unsigned ADDR_W = 23
) ();
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output read, address, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/flash_sample_reader_stepper.sv
// flash_addr_stepper: song word-address register that wraps between START_ADDR and END_ADDR.
module flash_addr_stepper #(
    parameter int unsigned        ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0,
    parameter logic [ADDR_W-1:0]  END_ADDR   = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              dir,
    output logic [ADDR_W-1:0] addr
);

    // load jumps to the song edge matching dir; step moves one word with wrap-around
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= START_ADDR;
        end else if (load) begin
            addr <= dir ? END_ADDR : START_ADDR;
        end else if (step) begin
            if (!dir) begin
                addr <= (addr == END_ADDR) ? START_ADDR : addr + ADDR_W'(1);
            end else begin
                addr <= (addr == START_ADDR) ? END_ADDR : addr - ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches 32-bit song words from flash and plays two 8-bit samples per word on sample_tick.
// Optional readdatavalid watchdog enabled by defining FLASH_READ_TIMEOUT_EN.
module flash_sample_reader
    import flash_sample_reader_pkg::*;
#(
    parameter int unsigned        ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0]  START_ADDR = ADDR_W'(SONG_START_ADDR),
    parameter logic [ADDR_W-1:0]  END_ADDR   = ADDR_W'(SONG_END_ADDR)
`ifdef FLASH_READ_TIMEOUT_EN
    ,
    parameter int unsigned        TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_read,
    input  logic                         dir,
    input  logic                         restart,
    input  logic                         sample_tick,
    flash_sample_reader_if.master        flash_mem,
    output logic [SAMPLE_W-1:0]          audio_data,
    output logic                         dataReady,
    output logic                         readFinish,
    output logic                         read_timeout
);

    reader_state_t           state;
    logic [FLASH_DATA_W-1:0] word_q;
    logic                    dir_q;
    logic                    read_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    step_c;
    logic                    load_c;

`ifdef FLASH_READ_TIMEOUT_EN
    logic [WDOG_W-1:0]       wdog_q;
    logic                    timeout_q;
    assign read_timeout = timeout_q;
`else
    assign read_timeout = 1'b0;
`endif

    assign flash_mem.read       = read_q;
    assign flash_mem.address    = addr_q;
    assign flash_mem.byteenable = 4'b1111;

    // Address moves on the word boundary with the live dir, or reloads after a restart
    assign step_c = (state == ST_ADVANCE) && !restart;
    assign load_c = (state == ST_RESTART);

    flash_addr_stepper #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_stepper (
        .clk   (clk),
        .reset (reset),
        .load  (load_c),
        .step  (step_c),
        .dir   (dir),
        .addr  (addr_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_q     <= '0;
            dir_q      <= 1'b0;
            audio_data <= '0;
            read_q     <= 1'b0;
            dataReady  <= 1'b0;
            readFinish <= 1'b0;
`ifdef FLASH_READ_TIMEOUT_EN
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            dataReady  <= 1'b0;
            readFinish <= 1'b0;
`ifdef FLASH_READ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (restart) begin
                        readFinish <= 1'b1;
                        state      <= ST_RESTART;
                    end else if (start_read) begin
                        dir_q  <= dir;
                        read_q <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!flash_mem.waitrequest) begin
                        read_q <= 1'b0;
                        state  <= ST_WAIT_DATA;
`ifdef FLASH_READ_TIMEOUT_EN
                        wdog_q <= '0;
`endif
                    end
                end
                // A tick coinciding with readdatavalid is dropped; first half waits for the next one
                ST_WAIT_DATA: begin
                    if (flash_mem.readdatavalid) begin
                        word_q <= flash_mem.readdata;
                        state  <= ST_OUT_FIRST;
                    end
`ifdef FLASH_READ_TIMEOUT_EN
                    else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES)) begin
                        word_q    <= '0;
                        timeout_q <= 1'b1;
                        state     <= ST_OUT_FIRST;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
`endif
                end
                ST_OUT_FIRST: begin
                    if (sample_tick && start_read) begin
                        audio_data <= half_msb(word_q, dir_q);
                        state      <= ST_OUT_SECOND;
                    end
                end
                ST_OUT_SECOND: begin
                    if (sample_tick && start_read) begin
                        audio_data <= half_msb(word_q, !dir_q);
                        dataReady  <= 1'b1;
                        state      <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    if (restart) begin
                        readFinish <= 1'b1;
                        state      <= ST_RESTART;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RESTART: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Self-checking bench for flash_sample_reader: table of song words plus restart, pause,
// waitrequest-stall and (with FLASH_READ_TIMEOUT_EN) watchdog sequences.
module tb_flash_sample_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_read;
    logic        dir;
    logic        restart;
    logic        sample_tick;
    logic [7:0]  audio_data;
    logic        dataReady;
    logic        readFinish;
    logic        read_timeout;

    int checks = 0;
    int errors = 0;

    flash_sample_reader_if #(.ADDR_W(23)) bus ();

    flash_sample_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start_read   (start_read),
        .dir          (dir),
        .restart      (restart),
        .sample_tick  (sample_tick),
        .flash_mem    (bus),
        .audio_data   (audio_data),
        .dataReady    (dataReady),
        .readFinish   (readFinish),
        .read_timeout (read_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        if (a == 23'h0) return 32'hAABB_CCDD;
        return {8'h10 ^ a[7:0], 8'h20, 8'h30 ^ a[7:0], 8'h40};
    endfunction

    // Flash slave model: optional stall, 1..3 cycle read latency, optional no-response
    int          pend_cnt      = 0;
    logic [22:0] pend_addr     = '0;
    logic [22:0] delivered_addr = '0;
    int          delivered_cnt = 0;
    int          consumed_cnt  = 0;
    int          stall_budget  = 0;
    bit          no_resp       = 1'b0;
    bit          to_seen       = 1'b0;

    always @(negedge clk) begin
        bus.readdatavalid = 1'b0;
        if (pend_cnt != 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                bus.readdata      = mem_word(pend_addr);
                bus.readdatavalid = 1'b1;
                delivered_addr    = pend_addr;
                delivered_cnt     = delivered_cnt + 1;
            end
        end
        if (bus.read === 1'b1 && stall_budget > 0) begin
            bus.waitrequest = 1'b1;
            stall_budget    = stall_budget - 1;
        end else begin
            bus.waitrequest = 1'b0;
        end
        if (bus.read === 1'b1 && !bus.waitrequest && !no_resp) begin
            pend_addr = bus.address;
            pend_cnt  = int'($urandom_range(1, 3));
        end
    end

    always @(posedge clk) begin
        if (read_timeout === 1'b1) to_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [7:0] exp_q[$];

    task automatic do_tick(input logic [7:0] exp);
        @(negedge clk);
        sample_tick = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        sample_tick = 1'b0;
        check("audio", 32'(audio_data), 32'(exp_q.pop_front()));
    endtask

    typedef struct packed {
        logic [22:0] addr;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic        dir_late;
        logic        rst_req;
        logic        pause;
        logic        stall;
        logic [22:0] next;
    } vec_t;

    vec_t vecs[9];

    task automatic consume(input vec_t v);
        bit got;
        if (v.stall) begin
            stall_budget = 5;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(posedge clk); #1;
                if (bus.read === 1'b1) got = 1'b1;
            end
            check("stall_req_seen", 32'(got), 32'd1);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check("stall_read_held", 32'(bus.read), 32'd1);
                check("stall_addr_held", 32'(bus.address), 32'(v.addr));
            end
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (delivered_cnt > consumed_cnt) got = 1'b1;
        end
        check("word_delivered", 32'(got), 32'd1);
        consumed_cnt = delivered_cnt;
        check("req_addr", 32'(delivered_addr), 32'(v.addr));
        if (v.rst_req) restart = 1'b1;
        do_tick(v.a1);
        if (v.pause) begin
            start_read = 1'b0;
            for (int i = 0; i < 10; i++) begin
                do_tick(v.a1);
                check("pause_read", 32'(bus.read), 32'd0);
            end
            start_read = 1'b1;
        end
        dir = v.dir_late;
        do_tick(v.a2);
        check("dataReady_hi", 32'(dataReady), 32'd1);
        @(negedge clk);
        check("dataReady_lo", 32'(dataReady), 32'd0);
        if (v.rst_req) begin
            check("readFinish_hi", 32'(readFinish), 32'd1);
            restart = 1'b0;
            @(negedge clk);
            check("readFinish_lo", 32'(readFinish), 32'd0);
        end
        check("next_addr", 32'(bus.address), 32'(v.next));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{addr:23'h00000, a1:8'hCC, a2:8'hAA, dir_late:1'b0, rst_req:1'b0, pause:1'b0, stall:1'b0, next:23'h00001};
        vecs[1] = '{addr:23'h00001, a1:8'h31, a2:8'h11, dir_late:1'b1, rst_req:1'b0, pause:1'b0, stall:1'b0, next:23'h00000};
        vecs[2] = '{addr:23'h00000, a1:8'hAA, a2:8'hCC, dir_late:1'b1, rst_req:1'b0, pause:1'b0, stall:1'b0, next:23'h7FFFF};
        vecs[3] = '{addr:23'h7FFFF, a1:8'hEF, a2:8'hCF, dir_late:1'b0, rst_req:1'b0, pause:1'b0, stall:1'b0, next:23'h00000};
        vecs[4] = '{addr:23'h00000, a1:8'hCC, a2:8'hAA, dir_late:1'b0, rst_req:1'b0, pause:1'b0, stall:1'b0, next:23'h00001};
        vecs[5] = '{addr:23'h00001, a1:8'h31, a2:8'h11, dir_late:1'b0, rst_req:1'b1, pause:1'b0, stall:1'b0, next:23'h00000};
        vecs[6] = '{addr:23'h00000, a1:8'hCC, a2:8'hAA, dir_late:1'b1, rst_req:1'b1, pause:1'b0, stall:1'b0, next:23'h7FFFF};
        vecs[7] = '{addr:23'h7FFFF, a1:8'hEF, a2:8'hCF, dir_late:1'b1, rst_req:1'b0, pause:1'b1, stall:1'b0, next:23'h7FFFE};
        vecs[8] = '{addr:23'h7FFFE, a1:8'hEE, a2:8'hCE, dir_late:1'b1, rst_req:1'b0, pause:1'b0, stall:1'b1, next:23'h7FFFD};

        reset       = 1'b1;
        start_read  = 1'b0;
        dir         = 1'b0;
        restart     = 1'b0;
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_audio",      32'(audio_data),     32'h0);
        check("rst_address",    32'(bus.address),    32'h0);
        check("rst_read",       32'(bus.read),       32'h0);
        check("rst_dataReady",  32'(dataReady),      32'h0);
        check("rst_readFinish", 32'(readFinish),     32'h0);
        check("rst_timeout",    32'(read_timeout),   32'h0);
        check("byteenable",     32'(bus.byteenable), 32'hF);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_no_read", 32'(bus.read), 32'h0);

        start_read = 1'b1;
        for (int i = 0; i < 9; i++) consume(vecs[i]);

`ifdef FLASH_READ_TIMEOUT_EN
        begin
            bit hit;
            no_resp = 1'b1;
            hit = 1'b0;
            for (int i = 0; i < 600 && !hit; i++) begin
                @(posedge clk); #1;
                if (read_timeout === 1'b1) hit = 1'b1;
            end
            check("timeout_pulse", 32'(hit), 32'd1);
            check("timeout_addr", 32'(bus.address), 32'h7FFFD);
            @(posedge clk); #1;
            check("timeout_one_cycle", 32'(read_timeout), 32'd0);
            no_resp = 1'b0;
            do_tick(8'h00);
            do_tick(8'h00);
            check("timeout_dataReady", 32'(dataReady), 32'd1);
        end
`else
        check("no_timeout_pulse", 32'(to_seen), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
